memory_arbiter: RTL

//  Two-master, one-slave arbiter that shares the SOC's single unified memory

---
 rtl/memory_arbiter.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/memory_arbiter.sv
// Round-robin arbiter between I-cache and D-cache refill ports onto one memory
// bank, one transaction in flight, with a watchdog that aborts a hung access.
module memory_arbiter #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    i_req,
   input  logic [ADDR_WIDTH-1:0]   i_addr,
   output logic [DATA_WIDTH-1:0]   i_rdata,
   output logic                    i_ack,
   output logic                    i_err,
   input  logic                    d_req,
   input  logic                    d_we,
   input  logic [ADDR_WIDTH-1:0]   d_addr,
   input  logic [DATA_WIDTH-1:0]   d_wdata,
   input  logic [DATA_WIDTH/8-1:0] d_wstrb,
   output logic [DATA_WIDTH-1:0]   d_rdata,
   output logic                    d_ack,
   output logic                    d_err,
   output logic                    m_req,
   output logic                    m_we,
   output logic [ADDR_WIDTH-1:0]   m_addr,
   output logic [DATA_WIDTH-1:0]   m_wdata,
   output logic [DATA_WIDTH/8-1:0] m_wstrb,
   input  logic [DATA_WIDTH-1:0]   m_rdata,
   input  logic                    m_ack,
   output logic                    grant_d,
   output logic                    busy
);

   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUS  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic                    last_d_q, last_d_d;
   logic                    grant_d_q, grant_d_d;
   logic                    busy_q, busy_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    m_req_q, m_req_d;
   logic                    m_we_q, m_we_d;
   logic [ADDR_WIDTH-1:0]   m_addr_q, m_addr_d;
   logic [DATA_WIDTH-1:0]   m_wdata_q, m_wdata_d;
   logic [STRB_W-1:0]       m_wstrb_q, m_wstrb_d;
   logic [DATA_WIDTH-1:0]   i_rdata_q, i_rdata_d;
   logic [DATA_WIDTH-1:0]   d_rdata_q, d_rdata_d;
   logic                    i_ack_q, i_ack_d;
   logic                    i_err_q, i_err_d;
   logic                    d_ack_q, d_ack_d;
   logic                    d_err_q, d_err_d;
   logic                    pick_d_s;
   logic                    timeout_s;

   // D wins when it is alone, or on a tie when I was served last.
   assign pick_d_s  = d_req & (~i_req | ~last_d_q);
   assign timeout_s = (TIMEOUT_CYCLES > 0) && (cnt_q == CNT_LAST);

   // Next-state and output logic.
   always_comb begin
      state_d   = state_q;
      last_d_d  = last_d_q;
      grant_d_d = grant_d_q;
      cnt_d     = cnt_q;
      m_req_d   = m_req_q;
      m_we_d    = m_we_q;
      m_addr_d  = m_addr_q;
      m_wdata_d = m_wdata_q;
      m_wstrb_d = m_wstrb_q;
      i_rdata_d = i_rdata_q;
      d_rdata_d = d_rdata_q;
      i_ack_d   = 1'b0;
      i_err_d   = 1'b0;
      d_ack_d   = 1'b0;
      d_err_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (i_req | d_req) begin
               state_d   = ST_BUS;
               grant_d_d = pick_d_s;
               m_req_d   = 1'b1;
               cnt_d     = {CNT_W{1'b0}};
               if (pick_d_s) begin
                  m_we_d    = d_we;
                  m_addr_d  = d_addr;
                  m_wdata_d = d_wdata;
                  m_wstrb_d = d_wstrb;
               end else begin
                  m_we_d    = 1'b0;
                  m_addr_d  = i_addr;
                  m_wdata_d = {DATA_WIDTH{1'b0}};
                  m_wstrb_d = {STRB_W{1'b0}};
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_BUS: begin
            if (m_ack) begin
               state_d = ST_DONE;
               m_req_d = 1'b0;
               if (grant_d_q) begin
                  d_rdata_d = m_rdata;
                  d_ack_d   = 1'b1;
               end else begin
                  i_rdata_d = m_rdata;
                  i_ack_d   = 1'b1;
               end
            end else if (timeout_s) begin
               // Abort: zero data plus error alongside the ack.
               state_d = ST_DONE;
               m_req_d = 1'b0;
               cnt_d   = cnt_q + CNT_ONE;
               if (grant_d_q) begin
                  d_rdata_d = {DATA_WIDTH{1'b0}};
                  d_ack_d   = 1'b1;
                  d_err_d   = 1'b1;
               end else begin
                  i_rdata_d = {DATA_WIDTH{1'b0}};
                  i_ack_d   = 1'b1;
                  i_err_d   = 1'b1;
               end
            end else begin
               if (cnt_q != CNT_MAX) begin
                  cnt_d = cnt_q + CNT_ONE;
               end else begin
                  cnt_d = cnt_q;
               end
            end
         end
         ST_DONE: begin
            state_d  = ST_IDLE;
            last_d_d = grant_d_q;
         end
         default: begin
            state_d = ST_IDLE;
            m_req_d = 1'b0;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         last_d_q  <= 1'b1;
         grant_d_q <= 1'b0;
         busy_q    <= 1'b0;
         cnt_q     <= {CNT_W{1'b0}};
         m_req_q   <= 1'b0;
         m_we_q    <= 1'b0;
         m_addr_q  <= {ADDR_WIDTH{1'b0}};
         m_wdata_q <= {DATA_WIDTH{1'b0}};
         m_wstrb_q <= {STRB_W{1'b0}};
         i_rdata_q <= {DATA_WIDTH{1'b0}};
         d_rdata_q <= {DATA_WIDTH{1'b0}};
         i_ack_q   <= 1'b0;
         i_err_q   <= 1'b0;
         d_ack_q   <= 1'b0;
         d_err_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         last_d_q  <= last_d_d;
         grant_d_q <= grant_d_d;
         busy_q    <= busy_d;
         cnt_q     <= cnt_d;
         m_req_q   <= m_req_d;
         m_we_q    <= m_we_d;
         m_addr_q  <= m_addr_d;
         m_wdata_q <= m_wdata_d;
         m_wstrb_q <= m_wstrb_d;
         i_rdata_q <= i_rdata_d;
         d_rdata_q <= d_rdata_d;
         i_ack_q   <= i_ack_d;
         i_err_q   <= i_err_d;
         d_ack_q   <= d_ack_d;
         d_err_q   <= d_err_d;
      end
   end

   assign i_rdata = i_rdata_q;
   assign i_ack   = i_ack_q;
   assign i_err   = i_err_q;
   assign d_rdata = d_rdata_q;
   assign d_ack   = d_ack_q;
   assign d_err   = d_err_q;
   assign m_req   = m_req_q;
   assign m_we    = m_we_q;
   assign m_addr  = m_addr_q;
   assign m_wdata = m_wdata_q;
   assign m_wstrb = m_wstrb_q;
   assign grant_d = grant_d_q;
   assign busy    = busy_q;

endmodule
